keypad_event_ctrl: RTL and testbench
====================================

// Module: keypad_event_ctrl
// PURPOSE
//  Sequences raw scanner output (4-bit code + level valid) into discrete key events.
//  Qualifies a press by stability, enforces release before next press, queues events
//  in a FIFO, and hands them to a consumer over a valid/ready handshake.
//  Sits between the hex keypad scanner and system logic (UI FSM, CPU register).
// PARAMETERS
//  FIFO_DEPTH      8      event FIFO entries; power of 2, >=2
//  STABLE_CYCLES   16     cycles code must be valid and unchanged to accept a press (>=1)
//  RELEASE_CYCLES  16     consecutive cycles key_valid low to declare release (>=1)
//  REPEAT_DELAY    500000 cycles from accepted press to first repeat (auto-repeat only)
//  REPEAT_RATE     100000 cycles between subsequent repeats (auto-repeat only)
//  CNT_W           20     timer width; must hold max of all cycle parameters
// PORTS
//  clock        in   1   clock
//  reset        in   1   reset, asynchronous, active-low
//  enable       in   1   1 = accept presses; 0 = FSM forced to IDLE, FIFO kept
//  key_valid    in   1   scanner: key currently detected (level)
//  key_code     in   4   scanner: code 0x0-0xF, meaningful when key_valid=1
//  evt_valid    out  1   FIFO non-empty; head event on evt_code
//  evt_code     out  4   head event code
//  evt_ready    in   1   consumer pops head when evt_valid & evt_ready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  entries held
//  overflow     out  1   sticky: event dropped because FIFO full
//  overflow_clr in   1   clears overflow (set wins if same cycle)
// BEHAVIOUR
//  Reset: FSM=IDLE, timers=0, FIFO empty, evt_valid=0, evt_code=0, fifo_level=0,
//   overflow=0. Reset mid-operation discards queued events and any press in progress.
//  FSM states:
//   IDLE:    key_valid=1 & enable -> QUALIFY, latch cand=key_code, timer=1.
//   QUALIFY: key_valid=0 or key_code!=cand -> IDLE (no event).
//            timer reaches STABLE_CYCLES -> push cand, -> PRESSED, timer=0.
//   PRESSED: key_valid=0 -> RELEASE, timer=1. Code change while pressed ignored
//            (no rollover; new key needs full release first).
//   RELEASE: key_valid=1 -> PRESSED (bounce; no new event), timer reset.
//            timer reaches RELEASE_CYCLES -> IDLE.
//  enable=0: next state IDLE from any state, no pushes; FIFO pops continue.
//  Latency: key held steady from cycle N -> push at end of cycle N+STABLE_CYCLES-1;
//   evt_valid high the following cycle (FIFO write-to-read 1 cycle, registered).
//  FIFO: evt_code = head, combinational from storage; pointers wrap mod FIFO_DEPTH.
//   Push when full and no pop same cycle -> dropped, overflow<=1.
//   Push+pop same cycle: both performed; level unchanged (legal when full or empty?
//   empty: no pop possible since evt_valid=0; push only).
//  evt_ready with evt_valid=0: no effect. evt_code stable while evt_valid & !evt_ready.
// CONFIGURATION
//  KEYPAD_AUTOREPEAT_EN defined: in PRESSED, with key_valid=1 and code==cand, repeat
//   timer counts; at REPEAT_DELAY push cand again, then every REPEAT_RATE cycles.
//   Timer clears on leaving PRESSED; bounce back from RELEASE restarts REPEAT_DELAY.
//   Repeats that hit a full FIFO set overflow like any push.
//  Not defined: exactly one event per press; repeat timer and parameters unused.
// TESTING (STABLE_CYCLES=4, RELEASE_CYCLES=4, FIFO_DEPTH=4, REPEAT_DELAY=20, RATE=8)
//  1 Hold code 0x5 10 cycles, release 6, evt_ready=1 -> exactly one evt 0x5, 1 cycle
//    after 4th stable cycle; level returns to 0.
//  2 Glitch: code 0x3 for 3 cycles then key_valid=0 -> no event; FSM back in IDLE.
//  3 Press 0x7, release bounce (low 2, high 1, low 5) -> single event 0x7.
//  4 evt_ready=0, six distinct presses -> level=4, events 1-4 in order, overflow=1;
//    overflow_clr -> 0; pop all -> codes in press order.
//  5 Level=4, push and pop same cycle -> level stays 4, no overflow, order kept.
//  6 KEYPAD_AUTOREPEAT_EN, hold 0xA 40 cycles -> events at press, +20, +28, +36;
//    without macro -> one event. Assert reset mid-hold -> all outputs to reset values.

Source files
------------

// File: rtl/keypad_event_ctrl.sv
// Turns raw keypad scanner output into debounced key events and queues them for a valid/ready consumer.
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_event_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int STABLE_CYCLES  = 16,
  parameter int RELEASE_CYCLES = 16,
  parameter int REPEAT_DELAY   = 500000,
  parameter int REPEAT_RATE    = 100000,
  parameter int CNT_W          = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          evt_valid,
  output logic [3:0]                    evt_code,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STB_LAST      = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST      = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam bit STB_ONE = (STABLE_CYCLES == 1);
  localparam bit REL_ONE = (RELEASE_CYCLES == 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, QUALIFY, PRESSED, RELEASE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   rpt_timer;
  logic               rpt_first;
  logic [3:0]         cand;
  logic               fsm_push;
  logic               rpt_push;
  logic               push;
  logic [3:0]         push_code;
  logic               pop;
  logic               full;
  logic               do_push;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [3:0]         mem [FIFO_DEPTH];

  // Press acceptance happens in the same cycle the last stable sample is seen.
  always_comb begin
    fsm_push  = 1'b0;
    push_code = cand;
    if (enable) begin
      case (state)
        IDLE:    if (key_valid && STB_ONE) begin
                   fsm_push  = 1'b1;
                   push_code = key_code;
                 end
        QUALIFY: if (key_valid && key_code == cand && timer == STB_LAST) fsm_push = 1'b1;
        default: ;
      endcase
    end
  end

  assign rpt_push = AUTOREPEAT && enable && state == PRESSED && key_valid && key_code == cand &&
                    rpt_timer == (rpt_first ? RPT_DLY_LAST : RPT_RATE_LAST);
  assign push     = fsm_push | rpt_push;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else if (!enable) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: if (key_valid) begin
          state <= STB_ONE ? PRESSED : QUALIFY;
          timer <= STB_ONE ? '0 : CNT_W'(1);
        end
        QUALIFY: if (!key_valid || key_code != cand) begin
          state <= IDLE;
          timer <= '0;
        end else if (fsm_push) begin
          state <= PRESSED;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
        PRESSED: if (!key_valid) begin
          state <= REL_ONE ? IDLE : RELEASE;
          timer <= REL_ONE ? '0 : CNT_W'(1);
        end
        RELEASE: if (key_valid) begin
          state <= PRESSED;
          timer <= '0;
        end else if (timer == REL_LAST) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enable && state == IDLE && key_valid) cand <= key_code;
  end

  // Repeat timer only runs while the accepted key is still held; any exit restarts the delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_timer <= '0;
      rpt_first <= 1'b1;
    end else if (AUTOREPEAT && enable && state == PRESSED && key_valid) begin
      if (key_code == cand) begin
        if (rpt_push) begin
          rpt_timer <= '0;
          rpt_first <= 1'b0;
        end else begin
          rpt_timer <= rpt_timer + 1'b1;
        end
      end
    end else begin
      rpt_timer <= '0;
      rpt_first <= 1'b1;
    end
  end

  assign evt_valid = (fifo_level != '0);
  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign do_push   = push & (~full | pop);
  assign evt_code  = evt_valid ? mem[rd_ptr] : 4'h0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: directed keypad scenarios plus random key activity against a rule-level model.
module tb_keypad_event_ctrl;

  localparam int DEPTH = 4;
  localparam int S     = 4;
  localparam int R     = 4;
  localparam int DLY   = 20;
  localparam int RATE  = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       evt_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic [2:0] fifo_level;
  logic       overflow;

  keypad_event_ctrl #(
    .FIFO_DEPTH(DEPTH), .STABLE_CYCLES(S), .RELEASE_CYCLES(R),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(20)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .key_valid(key_valid),
    .key_code(key_code), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(evt_ready), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  int         mcount, shown_level, run, low_run, rpt;
  bit         movf, shown_ovf, armed, first, prev_kv;
  logic [3:0] cur;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function void model_clear();
    mcount = 0; movf = 0; shown_level = 0; shown_ovf = 0;
    armed = 1; run = 0; low_run = 0; rpt = 0; first = 1; prev_kv = 0; cur = 4'h0;
    exp_q.delete();
  endfunction

  // Predicts the effect of the coming clock edge from the inputs now driven.
  function void model_step();
    bit pop, hit;
    logic [3:0] pc;
    shown_level = mcount;
    shown_ovf   = movf;
    pop = (mcount > 0) && evt_ready;
    hit = 0;
    pc  = cur;
    if (!enable) begin
      armed = 1; run = 0; low_run = 0; rpt = 0; first = 1;
    end else if (armed) begin
      if (!key_valid) run = 0;
      else if (run != 0 && key_code != cur) run = 0;
      else begin
        if (run == 0) cur = key_code;
        run++;
        if (run == S) begin
          hit = 1; pc = cur; armed = 0; run = 0; low_run = 0; rpt = 0; first = 1;
        end
      end
    end else if (!key_valid) begin
      low_run++; rpt = 0; first = 1;
      if (low_run == R) begin armed = 1; low_run = 0; end
    end else begin
      low_run = 0;
      if (RPT && prev_kv && key_code == cur) begin
        rpt++;
        if (rpt == (first ? DLY : RATE)) begin hit = 1; pc = cur; rpt = 0; first = 0; end
      end
    end
    prev_kv = key_valid;
    if (hit && mcount == DEPTH && !pop) movf = 1;
    else if (overflow_clr)              movf = 0;
    if (hit && (mcount < DEPTH || pop)) begin exp_q.push_back(pc); mcount++; end
    if (pop) mcount--;
  endfunction

  task automatic step(input logic kv, input logic [3:0] c, input logic rdy,
                      input logic en, input logic clr);
    @(posedge clock);
    #1;
    key_valid = kv; key_code = c; evt_ready = rdy; enable = en; overflow_clr = clr;
    model_step();
  endtask

  task automatic hold(input int n, input logic kv, input logic [3:0] c, input logic rdy);
    repeat (n) step(kv, c, rdy, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_code", int'(evt_code), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    model_step();
  endtask

  // Scoreboard monitor: checks status every cycle and the head event on each handshake.
  always @(negedge clock) begin
    if (reset) begin
      chk("fifo_level", int'(fifo_level), shown_level);
      chk("evt_valid", int'(evt_valid), int'(shown_level != 0));
      chk("overflow", int'(overflow), int'(shown_ovf));
      if (evt_valid) begin
        chk("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("evt_code", int'(evt_code), int'(exp_q[0]));
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    enable = 1'b1;
    #2;
    do_reset();

    hold(10, 1'b1, 4'h5, 1'b1);
    hold(6, 1'b0, 4'h0, 1'b1);

    hold(3, 1'b1, 4'h3, 1'b1);
    hold(6, 1'b0, 4'h0, 1'b1);

    hold(5, 1'b1, 4'h7, 1'b1);
    hold(2, 1'b0, 4'h0, 1'b1);
    hold(1, 1'b1, 4'h7, 1'b1);
    hold(5, 1'b0, 4'h0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      hold(S, 1'b1, 4'(i + 1), 1'b0);
      hold(R, 1'b0, 4'h0, 1'b0);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

    hold(3, 1'b1, 4'hC, 1'b0);
    hold(1, 1'b1, 4'hC, 1'b1);
    hold(8, 1'b0, 4'h0, 1'b1);

    hold(40, 1'b1, 4'hA, 1'b1);
    hold(6, 1'b0, 4'h0, 1'b1);

    hold(15, 1'b1, 4'hA, 1'b1);
    do_reset();
    hold(10, 1'b1, 4'hA, 1'b1);
    hold(6, 1'b0, 4'h0, 1'b1);

    for (int seg = 0; seg < 150; seg++) begin
      logic [3:0] code;
      int len;
      code = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 45);
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 19) != 0,
             ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : code,
             $urandom_range(0, 9) < 6, $urandom_range(0, 49) != 0,
             $urandom_range(0, 29) == 0);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++)
        step(1'b0, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6,
             1'b1, $urandom_range(0, 29) == 0);
    end

    hold(20, 1'b0, 4'h0, 1'b1);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
